// File: rtl/muldiv_seq_if.sv
// Request/response bundle of the sequential RV64M multiply/divide unit.
// The master drives requests and accepts responses; the slave is muldiv_seq.
interface muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      op;
  logic            width_32;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, op, width_32, a, b, flush, resp_ready,
    input  req_ready, resp_valid, result, busy
  );

  modport slave (
    input  req_valid, op, width_32, a, b, flush, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV64M multiply/divide: radix-2 restoring divider and shift-add multiplier.
// Optional macro MULDIV_FAST_MUL_EN swaps the iterative multiplier for a single-cycle one.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_n;
  logic [2:0]      op_q;
  logic            w32_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   cnt_q;

  logic            in_div, in_sa, in_sb, a_neg, b_neg;
  logic            div_zero, div_ovf, mulw_bad, special;
  logic [XLEN-1:0] a_mag, b_mag, a_ext, special_res;

  logic            accept, step, finish, last;
  logic [XLEN:0]   shifted, diff, sum;
  logic [XLEN-1:0] step_acc, step_lo, fin_acc, fin_lo, fin_res, div_mag;
  logic [HALF-1:0] div_val32;
  logic [2*XLEN-1:0] prod;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Incoming request decode: operand signs, magnitudes and the short-circuit cases.
  always_comb begin
    in_div = bus.op[2];
    in_sa  = in_div ? !bus.op[0] : (bus.op == 3'b001 || bus.op == 3'b010);
    in_sb  = in_div ? !bus.op[0] : (bus.op == 3'b001);
    if (bus.width_32) begin
      a_neg    = in_sa && bus.a[HALF-1];
      b_neg    = in_sb && bus.b[HALF-1];
      a_mag    = {{HALF{1'b0}}, (a_neg ? -bus.a[HALF-1:0] : bus.a[HALF-1:0])};
      b_mag    = {{HALF{1'b0}}, (b_neg ? -bus.b[HALF-1:0] : bus.b[HALF-1:0])};
      a_ext    = {{HALF{bus.a[HALF-1]}}, bus.a[HALF-1:0]};
      div_zero = (bus.b[HALF-1:0] == '0);
      div_ovf  = in_div && in_sa && (bus.a[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                 && (bus.b[HALF-1:0] == '1);
    end else begin
      a_neg    = in_sa && bus.a[XLEN-1];
      b_neg    = in_sb && bus.b[XLEN-1];
      a_mag    = a_neg ? -bus.a : bus.a;
      b_mag    = b_neg ? -bus.b : bus.b;
      a_ext    = bus.a;
      div_zero = (bus.b == '0);
      div_ovf  = in_div && in_sa && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    end
    mulw_bad = !in_div && bus.width_32 && (bus.op != 3'b000);
    special  = mulw_bad || (in_div && (div_zero || div_ovf));

    special_res = '0;
    if (in_div && div_zero)
      special_res = bus.op[1] ? a_ext : '1;
    else if (in_div && div_ovf)
      special_res = bus.op[1] ? '0 : a_ext;
  end

  // One iteration of the active engine plus the sign-corrected final result.
  always_comb begin
    shifted = {acc_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    if (op_q[2]) begin
      step_acc = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      step_acc = sum[XLEN:1];
      step_lo  = {sum[0], lo_q[XLEN-1:1]};
    end
    fin_acc = step_acc;
    fin_lo  = step_lo;
    last    = (cnt_q == (w32_q ? CW'(HALF - 1) : CW'(XLEN - 1)));
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, lo_q};
    // Align W products with the iterative layout so finalisation is shared.
    if (w32_q)
      fast_prod = fast_prod << HALF;
    if (!op_q[2]) begin
      {fin_acc, fin_lo} = fast_prod;
      last              = 1'b1;
    end
`endif

    div_mag   = op_q[1] ? fin_acc : fin_lo;
    div_val32 = neg_q ? -div_mag[HALF-1:0] : div_mag[HALF-1:0];
    prod      = {fin_acc, fin_lo};
    if (neg_q)
      prod = -prod;

    if (op_q[2])
      fin_res = w32_q ? {{HALF{div_val32[HALF-1]}}, div_val32} : (neg_q ? -div_mag : div_mag);
    else if (w32_q)
      fin_res = {{HALF{prod[XLEN-1]}}, prod[XLEN-1:HALF]};
    else if (op_q[1:0] == 2'b00)
      fin_res = prod[XLEN-1:0];
    else
      fin_res = prod[2*XLEN-1:XLEN];
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_n        = state_q;
    accept         = 1'b0;
    step           = 1'b0;
    finish         = 1'b0;
    bus.req_ready  = (state_q == IDLE) && !bus.flush;
    bus.resp_valid = (state_q == DONE);
    bus.busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept  = 1'b1;
          state_n = special ? DONE : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last && !bus.flush) begin
          finish  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (bus.flush)
      state_n = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_n;
  end

  // NOTE: datapath registers are reset too, so result reads 0 straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      w32_q    <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      w32_q  <= bus.width_32;
      neg_q  <= (in_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
      acc_q  <= '0;
      cnt_q  <= '0;
      // Divide shifts the dividend out of lo from the top; W dividends start left-aligned.
      if (in_div) begin
        lo_q   <= bus.width_32 ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
        opnd_q <= b_mag;
      end else begin
        lo_q   <= b_mag;
        opnd_q <= a_mag;
      end
      if (special)
        result_q <= special_res;
    end else if (step) begin
      acc_q <= step_acc;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + 1'b1;
      if (finish)
        result_q <= fin_res;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases, randomized ops against
// an arithmetic reference model, backpressure, flush and asynchronous reset.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(64)) bus ();
  muldiv_seq #(.XLEN(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  function automatic vec_t mk(string name, logic [2:0] op, logic w, logic [63:0] a,
                              logic [63:0] b, logic [63:0] exp, int lat);
    vec_t v;
    v.name = name; v.op = op; v.w = w; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Reference result straight from RISC-V M-extension arithmetic rules.
  function automatic logic [63:0] ref_result(logic [2:0] op, logic w, logic [63:0] a, logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  r32, ua, ub;
    longint       sa, sb;
    int           sa32, sb32;
    if (!op[2]) begin
      if (w) begin
        if (op != OP_MUL) return 64'd0;
        r32 = a[31:0] * b[31:0];
        return {{32{r32[31]}}, r32};
      end
      case (op[1:0])
        2'd0:    p = {64'd0, a} * {64'd0, b};
        2'd1:    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        2'd2:    p = {{64{a[63]}}, a} * {64'd0, b};
        default: p = {64'd0, a} * {64'd0, b};
      endcase
      return (op[1:0] == 2'd0) ? p[63:0] : p[127:64];
    end
    if (w) begin
      ua = a[31:0]; ub = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
      if (ub == 32'd0)
        r32 = op[1] ? ua : 32'hFFFF_FFFF;
      else if (!op[0] && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF)
        r32 = op[1] ? 32'd0 : ua;
      else if (!op[0])
        r32 = op[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      else
        r32 = op[1] ? ua % ub : ua / ub;
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b;
    if (b == 64'd0)
      return op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      return op[1] ? 64'd0 : a;
    if (!op[0])
      return op[1] ? 64'(sa % sb) : 64'(sa / sb);
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int ref_lat(logic [2:0] op, logic w, logic [63:0] a, logic [63:0] b);
    if (!op[2]) begin
      if (w && op != OP_MUL) return 1;
      if (FAST) return 2;
      return w ? 33 : 65;
    end
    if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
    if (!op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
      return 1;
    return w ? 33 : 65;
  endfunction

  // Drive one request and return just after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.op = op; bus.width_32 = w; bus.a = a; bus.b = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as 1; a stuck DUT is flushed after the budget.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
    end
  endtask

  task automatic retire();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
  endtask

  task automatic test_directed();
    vec_t vecs[12];
    logic [63:0] res;
    int lat;
    vecs[0]  = mk("div_neg",   OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    vecs[1]  = mk("rem_neg",   OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    vecs[2]  = mk("divu_zero", OP_DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    vecs[3]  = mk("remu_zero", OP_REMU, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    vecs[4]  = mk("div_ovf",   OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 1);
    vecs[5]  = mk("remw_ovf",  OP_REM,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
    vecs[6]  = mk("mulhu_max", OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFE, FAST ? 2 : 65);
    vecs[7]  = mk("mulw_wrap", OP_MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, FAST ? 2 : 33);
    vecs[8]  = mk("mulhw_bad", OP_MULH, 1'b1, 64'd5, 64'd7, 64'd0, 1);
    vecs[9]  = mk("divuw_pos", OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'h0000_0000_7FFF_FFF8, 33);
    vecs[10] = mk("remw_neg",  OP_REM,  1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    vecs[11] = mk("divw_zero", OP_DIV,  1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b);
      wait_resp(lat);
      res = bus.result;
      retire();
      total++;
      if (res !== vecs[i].exp) begin
        bad++; $display("FAIL %s result got=%h exp=%h", vecs[i].name, res, vecs[i].exp);
      end
      total++;
      if (lat != vecs[i].lat) begin
        bad++; $display("FAIL %s latency got=%0d exp=%0d", vecs[i].name, lat, vecs[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b, res, exp;
    int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 3) == 0);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: ;
        1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50));
                 if ($urandom_range(0, 1) == 1) a = -a;
                 if ($urandom_range(0, 1) == 1) b = -b; end
        2: b = w ? {$urandom, 32'd0} : 64'd0;
        3: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        default: b = 64'($urandom_range(1, 300));
      endcase
      exp     = ref_result(op, w, a, b);
      exp_lat = ref_lat(op, w, a, b);
      start_op(op, w, a, b);
      wait_resp(lat);
      res = bus.result;
      retire();
      total++;
      if (res !== exp) begin
        bad++; $display("FAIL rand%0d op=%0d w=%b a=%h b=%h got=%h exp=%h", i, op, w, a, b, res, exp);
      end
      total++;
      if (lat != exp_lat) begin
        bad++; $display("FAIL rand%0d_latency op=%0d w=%b got=%0d exp=%0d", i, op, w, lat, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.resp_ready = 1'b0;
    start_op(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    wait_resp(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.resp_valid !== 1'b1 || bus.result !== 64'hFFFF_FFFF_FFFF_FFFA || bus.req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d valid=%b result=%h req_ready=%b exp 1/fffffffffffffffa/0",
                        i, bus.resp_valid, bus.result, bus.req_ready);
      end
    end
    retire();
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release valid=%b req_ready=%b exp 0/1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.resp_ready = 1'b1;
    start_op(OP_DIVU, 1'b0, 64'd11, 64'd0);
    // Second request is already pending while the first response is being consumed.
    bus.op = OP_REMU; bus.a = 64'd7; bus.b = 64'd0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_no_same_cycle busy=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b1 || bus.result !== 64'd7) begin
      bad++; $display("FAIL b2b_second valid=%b result=%h exp 1/7", bus.resp_valid, bus.result);
    end
    retire();
    lat = 0;
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    bus.resp_ready = 1'b1;
    start_op(OP_DIVU, 1'b0, 64'd50, 64'd0);
    wait_resp(lat);
    retire();
    start_op(OP_DIV, 1'b0, 64'd123456, 64'd7);
    repeat (4) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL flush_calc valid=%b busy=%b req_ready=%b exp 0/0/1", bus.resp_valid, bus.busy, bus.req_ready);
    end
    total++;
    if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++; $display("FAIL flush_result_kept got=%h exp=ffffffffffffffff", bus.result);
    end
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (bus.resp_valid) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_resp got=%b exp=0", seen); end

    bus.resp_ready = 1'b0;
    start_op(OP_DIVU, 1'b0, 64'd9, 64'd0);
    bus.flush = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL flush_done valid=%b req_ready=%b exp 0/1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    bit seen;
    bus.resp_ready = 1'b1;
    start_op(OP_REMU, 1'b0, 64'd100, 64'd0);
    wait_resp(lat);
    retire();
    start_op(OP_DIV, 1'b0, 64'd1000, 64'd3);
    repeat (9) begin @(posedge clk); #1; end
    total++;
    if (bus.busy !== 1'b1 || bus.result !== 64'd100) begin
      bad++; $display("FAIL areset_pre busy=%b result=%h exp 1/100", bus.busy, bus.result);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'd0) begin
      bad++; $display("FAIL areset_now valid=%b busy=%b result=%h exp 0/0/0", bus.resp_valid, bus.busy, bus.result);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b exp=1", bus.req_ready); end
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (bus.resp_valid) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL areset_no_resp got=%b exp=0", seen); end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.op = 3'd0; bus.width_32 = 1'b0;
    bus.a = 64'd0; bus.b = 64'd0; bus.flush = 1'b0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand and result width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  operation request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  3  RV64M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port width_32  input  1  W-form operation (MULW/DIVW/DIVUW/REMW/REMUW).
REQ-008 SHALL have port a  input  64  rs1 operand.
REQ-009 SHALL have port b  input  64  rs2 operand.
REQ-010 SHALL have port flush  input  1  kill any in-flight operation.
REQ-011 SHALL have port resp_valid  output  1  result valid.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  64  operation result.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL drive req_ready = (state==IDLE) && !flush; accept occurs on an edge with req_valid && req_ready, latching op, width_32, a and b.
REQ-017 SHALL treat a request accepted with op, width_32 combination MUL-high + width_32 (funct3 001-011 with width_32) as MULW-illegal: result 0, go directly to DONE.
REQ-018 SHALL, on accept, go IDLE->CALC, except the special cases in REQ-021/022, which go IDLE->DONE (resp_valid 1 cycle after accept).
REQ-019 SHALL compute divide/remainder with a radix-2 restoring divider on operand magnitudes, iterating 64 cycles (32 for width_32) in CALC, then CALC->DONE; result signs corrected per RISC-V (quotient negative if signs differ, remainder takes dividend sign).
REQ-020 SHALL compute multiply with a radix-2 shift-add engine iterating 64 cycles (32 for MULW) in CALC on magnitudes, with two's-complement sign correction of the 128-bit product; MUL returns bits 63:0, MULH/MULHSU/MULHU bits 127:64.
REQ-021 SHALL, for divisor zero (b, or b[31:0] for W), return DIV/DIVU quotient all ones and REM/REMU remainder = dividend.
REQ-022 SHALL, for signed overflow (dividend most negative, divisor -1), return quotient = dividend and remainder 0.
REQ-023 SHALL, for width_32, operate on a[31:0], b[31:0] and sign-extend the 32-bit result to 64 bits (including DIVUW/REMUW).
REQ-024 SHALL hold resp_valid=1 and result stable in DONE until resp_valid && resp_ready, then DONE->IDLE; a new request is not accepted in the same cycle.
REQ-025 SHALL, on flush=1 in any state, return to IDLE on the next edge with resp_valid=0; flush in DONE concurrent with resp_ready drops the response.
REQ-026 SHALL keep result at its last value while not in DONE; result is only meaningful with resp_valid=1.

Reset
REQ-027 SHALL, on reset assertion, immediately force state IDLE, resp_valid 0, busy 0, result 0, all iteration counters and operand registers 0, independent of clk.
REQ-028 SHALL, on reset asserted mid-operation, abandon the operation with no response; req_ready rises once reset is released.

Configuration
REQ-029 SHALL honour macro MULDIV_FAST_MUL_EN: when defined, multiply ops use a single-cycle 64x64 multiplier and spend exactly one cycle in CALC (resp_valid 2 cycles after accept); when undefined, multiply uses the iterative engine of REQ-020; divide behaviour is identical in both builds.

Verification
REQ-030 SHALL verify DIV a=-20, b=3 -> result 0xFFFF_FFFF_FFFF_FFFA (-6), resp_valid 65 cycles after accept; REM same operands -> 0xFFFF_FFFF_FFFF_FFFE (-2).
REQ-031 SHALL verify DIVU a=100, b=0 -> result 0xFFFF_FFFF_FFFF_FFFF, resp_valid 1 cycle after accept; REMU -> 100.
REQ-032 SHALL verify DIV a=0x8000_0000_0000_0000, b=-1 -> result 0x8000_0000_0000_0000; REMW a=0x8000_0000, b=0xFFFF_FFFF -> 0.
REQ-033 SHALL verify MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULW a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE; latency 65/33 cycles, or 2 with MULDIV_FAST_MUL_EN.
REQ-034 SHALL verify backpressure and flush: hold resp_ready=0 for 10 cycles in DONE -> result stable and req_ready 0; flush at CALC cycle 5 -> IDLE next edge, no resp_valid, req_ready 1.
REQ-035 SHALL verify async reset pulsed mid-CALC with no clk edge -> resp_valid, busy, result all 0 immediately.
